// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: active-low glyphs
// ({g,f,e,d,c,b,a}, 0 = lit) and a sizing helper for counters.
package seg_pkg;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Bits needed to hold values 0..v-1; never less than 1 so that
    // degenerate sizes still give a legal vector.
    function automatic int clog2_u(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Nibble to active-low 7-segment glyph. Values above 9 render as
// A,b,C,d,E,F only in hex mode; otherwise they are blank.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output logic [6:0] seg_n
);

    // Pure lookup; hex glyphs gated by hex_mode.
    always_comb begin
        seg_n = SEG_OFF;
        case (nibble)
            4'h0: seg_n = SEG_0;
            4'h1: seg_n = SEG_1;
            4'h2: seg_n = SEG_2;
            4'h3: seg_n = SEG_3;
            4'h4: seg_n = SEG_4;
            4'h5: seg_n = SEG_5;
            4'h6: seg_n = SEG_6;
            4'h7: seg_n = SEG_7;
            4'h8: seg_n = SEG_8;
            4'h9: seg_n = SEG_9;
            4'hA: seg_n = hex_mode ? SEG_A : SEG_OFF;
            4'hB: seg_n = hex_mode ? SEG_B : SEG_OFF;
            4'hC: seg_n = hex_mode ? SEG_C : SEG_OFF;
            4'hD: seg_n = hex_mode ? SEG_D : SEG_OFF;
            4'hE: seg_n = hex_mode ? SEG_E : SEG_OFF;
            default: seg_n = hex_mode ? SEG_F : SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed, double-buffered multi-digit 7-segment driver for a
// common-anode array (all outputs active-low). Each digit slot is DIV
// cycles: BLANK_CYC dark cycles against ghosting, then the digit is driven.
// Optional: define SEG_SCAN_BLINK_EN to add a per-digit blink_mask input
// and a ~4 Hz blink phase that darkens masked digits.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int CLK_HZ    = 50_000_000,
    parameter int SCAN_HZ   = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  hex_mode,
    input  logic                  lzb,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [DIGITS-1:0]     blink_mask,
`endif
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     dig_n,
    output logic                  frame_done
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = clog2_u(DIV);
    localparam int IW  = clog2_u(DIGITS);

    localparam logic [PW-1:0] PMAX   = PW'(DIV - 1);
    localparam logic [PW-1:0] BSTART = PW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [IW-1:0] ILAST  = IW'(DIGITS - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    generate
        if (DIV < BLANK_CYC + 2) begin : g_bad_div
            $error("seg_scan_driver: CLK_HZ/SCAN_HZ must be >= BLANK_CYC+2");
        end
        if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
            $error("seg_scan_driver: DIGITS must be 1..8");
        end
    endgenerate

    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic [0:0]          state;
    logic                slot_end;
    logic                frame_start;

    logic [4*DIGITS-1:0] shd_data, act_data;
    logic [DIGITS-1:0]   shd_dp,   act_dp;

    logic [3:0]          cur_nib;
    logic [6:0]          glyph;
    logic                upper_zero;
    logic                lz_blank;
    logic                blink_off;

    assign slot_end    = (presc == PMAX);
    assign frame_start = slot_end && (idx == ILAST);

    // Slot timer and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (slot_end) begin
            presc <= '0;
            idx   <= (idx == ILAST) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Slot phase: state becomes DRIVE as presc reaches BLANK_CYC and
    // returns to BLANK as the slot wraps to presc 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_BLANK;
        else if (slot_end)
            state <= (BLANK_CYC == 0) ? ST_DRIVE : ST_BLANK;
        else if (BLANK_CYC > 0 && presc == BSTART)
            state <= ST_DRIVE;
    end

    // Double buffer: load fills the shadow; the displayed copy only changes
    // at a frame boundary, taking a coincident load directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd_data <= '0;
            shd_dp   <= '0;
            act_data <= '0;
            act_dp   <= '0;
        end else begin
            if (load) begin
                shd_data <= data;
                shd_dp   <= dp_in;
            end
            if (frame_start) begin
                act_data <= load ? data  : shd_data;
                act_dp   <= load ? dp_in : shd_dp;
            end
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int BW = (clog2_u(CLK_HZ) > 3) ? clog2_u(CLK_HZ) - 2 : 1;

    logic [DIGITS-1:0] shd_blink, act_blink;
    logic [BW-1:0]     bcnt;
    logic              bphase;

    // Blink mask follows the same shadow/active path as the digit data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd_blink <= '0;
            act_blink <= '0;
        end else begin
            if (load) shd_blink <= blink_mask;
            if (frame_start) act_blink <= load ? blink_mask : shd_blink;
        end
    end

    // Free-running blink timer; phase flips each time the counter wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt   <= '0;
            bphase <= 1'b0;
        end else begin
            bcnt <= bcnt + 1'b1;
            if (&bcnt) bphase <= ~bphase;
        end
    end

    assign blink_off = bphase && act_blink[idx];
`else
    assign blink_off = 1'b0;
`endif

    // Current digit value; digit k is a leading zero when it and every
    // more-significant nibble are zero. Digit 0 always shows.
    assign cur_nib    = act_data[4*idx +: 4];
    assign upper_zero = ~|(act_data >> (32'(idx) * 4));
    assign lz_blank   = lzb && (idx != '0) && upper_zero;

    seg_glyph_decode u_dec (
        .nibble   (cur_nib),
        .hex_mode (hex_mode),
        .seg_n    (glyph)
    );

    // Registered outputs, one cycle behind idx/state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n      <= SEG_OFF;
            dp_n       <= 1'b1;
            dig_n      <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_start;
            if (state == ST_DRIVE) begin
                dig_n <= ~(DIGITS'(1) << idx);
                seg_n <= (lz_blank || blink_off) ? SEG_OFF : glyph;
                dp_n  <= blink_off ? 1'b1 : ~act_dp[idx];
            end else begin
                dig_n <= '1;
                seg_n <= SEG_OFF;
                dp_n  <= 1'b1;
            end
        end
    end

endmodule
